// File: rtl/cut_bist_pkg.sv
// Shared types and MISR arithmetic for the CUT self-test harness.
// The testbench model uses the same misr_next() helper.
package cut_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StCheck
  } state_e;

  // Default MISR feedback polynomial for a given register width.
  function automatic logic [31:0] default_poly(input int unsigned w);
    case (w)
      16:      return 32'h0000_002D;
      default: return 32'h0000_001D;
    endcase
  endfunction

  // One MISR step at width w (1..32): shift, fold in the polynomial on carry-out, xor response.
  function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] resp,
                                            input logic [31:0] poly, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] nxt;
    logic [4:0]  top;
    top  = 5'(w - 1);
    mask = (w >= 32) ? '1 : ((32'h1 << w) - 32'h1);
    nxt  = (sig << 1) & mask;
    if (sig[top]) begin
      nxt = nxt ^ poly;
    end
    return (nxt ^ resp) & mask;
  endfunction

endpackage

// File: rtl/cut_bist_if.sv
// Control, pattern and response signals between a BIST host and the harness.
interface cut_bist_if #(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned N_OUT = 8
);
  logic             start_i;
  logic             abort_i;
  logic [N_IN-1:0]  pat_o;
  logic [N_OUT-1:0] resp_i;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic [N_OUT-1:0] sig_o;

  modport master (
    output start_i, abort_i, resp_i,
    input  pat_o, busy_o, done_o, pass_o, sig_o
  );

  modport slave (
    input  start_i, abort_i, resp_i,
    output pat_o, busy_o, done_o, pass_o, sig_o
  );
endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register with synchronous seed load and capture enable.
module bist_misr
  import cut_bist_pkg::*;
#(
  parameter int unsigned      N_OUT = 8,
  parameter logic [N_OUT-1:0] POLY  = N_OUT'(default_poly(N_OUT)),
  parameter logic [N_OUT-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [N_OUT-1:0] resp_i,
  output logic [N_OUT-1:0] sig_o
);

  logic [N_OUT-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = N_OUT'(misr_next(32'(sig_q), 32'(resp_i), 32'(POLY), N_OUT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/cut_bist_harness.sv
// Exhaustive-pattern BIST harness: sweeps all CUT inputs, compacts responses into a MISR
// and compares the final signature with a golden value.
module cut_bist_harness
  import cut_bist_pkg::*;
#(
  parameter int unsigned      N_IN   = 5,
  parameter int unsigned      N_OUT  = 8,
  parameter logic [N_OUT-1:0] POLY   = N_OUT'(default_poly(N_OUT)),
  parameter logic [N_OUT-1:0] SEED   = '0,
  parameter logic [N_OUT-1:0] GOLDEN = '0,
  parameter int unsigned      SETTLE = 1
) (
  input logic       clk,
  input logic       rst_n,
  cut_bist_if.slave bus
);

  localparam int unsigned     CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] PatLast = '1;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  pat_q, pat_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             misr_load, misr_en, done;
  logic [N_OUT-1:0] sig;
  logic             sig_match;

  assign sig_match = (sig == GOLDEN);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d   = StApply;
          pat_d     = '0;
          cnt_d     = '0;
          pass_d    = 1'b0;
          misr_load = 1'b1;
        end
      end
      StApply: begin
        if (bus.abort_i) begin
          state_d = StIdle;
          pass_d  = 1'b0;
        end else if (cnt_q == CntLast) begin
          misr_en = 1'b1;
          if (pat_q == PatLast) begin
            state_d = StCheck;
          end else begin
            pat_d = pat_q + 1'b1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (bus.abort_i) begin
          pass_d = 1'b0;
        end else begin
          done   = 1'b1;
          pass_d = sig_match;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pat_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  bist_misr #(
    .N_OUT (N_OUT),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (misr_load),
    .en_i   (misr_en),
    .resp_i (bus.resp_i),
    .sig_o  (sig)
  );

  // The verdict is visible in the same cycle as the done pulse, then held in pass_q.
  assign bus.pat_o  = pat_q;
  assign bus.busy_o = (state_q != StIdle);
  assign bus.done_o = done;
  assign bus.pass_o = done ? sig_match : pass_q;
  assign bus.sig_o  = sig;

endmodule

// File: tb/tb_cut_bist_harness.sv
// Scoreboard bench for cut_bist_harness: two instances (default, and GOLDEN=8'h1D with SETTLE=3).
module tb_cut_bist_harness;
  import cut_bist_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cut_bist_if #(.N_IN(5), .N_OUT(8)) if_a ();
  cut_bist_if #(.N_IN(5), .N_OUT(8)) if_b ();

  cut_bist_harness u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  cut_bist_harness #(
    .GOLDEN (8'h1D),
    .SETTLE (3)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  int mode_a = 0;
  int mode_b = 0;

  // Response patterns: 0 zero, 1 01@31, 2 80@30, 3 01@30..31, 4 5A@0.
  function automatic logic [7:0] resp_of(input int mode, input logic [4:0] p);
    case (mode)
      1:       return (p == 5'd31) ? 8'h01 : 8'h00;
      2:       return (p == 5'd30) ? 8'h80 : 8'h00;
      3:       return (p >= 5'd30) ? 8'h01 : 8'h00;
      4:       return (p == 5'd0)  ? 8'h5A : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  assign if_a.resp_i = resp_of(mode_a, if_a.pat_o);
  assign if_b.resp_i = resp_of(mode_b, if_b.pat_o);

  typedef struct {
    logic [7:0] sig;
    logic       pass;
    int         lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endfunction

  function automatic void on_done(input bit sel, input logic pass, input logic [7:0] sig,
                                  input int lat);
    exp_t e;
    if (sel ? (q_b.size() == 0) : (q_a.size() == 0)) begin
      n_chk++;
      $display("FAIL unexpected_done dut=%0d: got done with sig 0x%0h, want no done", sel, sig);
      return;
    end
    e = sel ? q_b.pop_front() : q_a.pop_front();
    check(sel ? "b_sig" : "a_sig", 32'(sig), 32'(e.sig));
    check(sel ? "b_pass" : "a_pass", 32'(pass), 32'(e.pass));
    check(sel ? "b_latency" : "a_latency", lat, e.lat);
  endfunction

  // Monitor: counts busy cycles and scores each done pulse against the queue.
  initial begin
    int cnt_a = 0;
    int cnt_b = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt_a = 0;
        cnt_b = 0;
      end else begin
        cnt_a = if_a.busy_o ? cnt_a + 1 : 0;
        cnt_b = if_b.busy_o ? cnt_b + 1 : 0;
        if (if_a.done_o) on_done(1'b0, if_a.pass_o, if_a.sig_o, cnt_a);
        if (if_b.done_o) on_done(1'b1, if_b.pass_o, if_b.sig_o, cnt_b);
      end
    end
  end

  // Returns at the falling edge of the first APPLY cycle.
  task automatic start_pulse(input bit sel);
    @(negedge clk);
    if (sel) if_b.start_i = 1'b1;
    else     if_a.start_i = 1'b1;
    @(negedge clk);
    if_a.start_i = 1'b0;
    if_b.start_i = 1'b0;
  endtask

  task automatic run(input bit sel, input int mode, input logic [7:0] esig, input bit epass,
                     input bit mid_start);
    int         settle;
    logic [4:0] p;
    exp_t       e;
    settle = sel ? 3 : 1;
    if (sel) mode_b = mode;
    else     mode_a = mode;
    e = '{esig, epass, 32 * settle + 1};
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    start_pulse(sel);
    for (int k = 0; k < 32 * settle; k++) begin
      p = sel ? if_b.pat_o : if_a.pat_o;
      check(sel ? "b_pat_sweep" : "a_pat_sweep", 32'(p), k / settle);
      if (mid_start) begin
        if (sel) if_b.start_i = (k == 15);
        else     if_a.start_i = (k == 15);
      end
      @(negedge clk);
    end
    if_a.start_i = 1'b0;
    if_b.start_i = 1'b0;
    @(negedge clk);
    check("busy_after_run", 32'(sel ? if_b.busy_o : if_a.busy_o), 0);
  endtask

  task automatic wait_pat_a(input logic [4:0] target);
    int i;
    for (i = 0; i < 40 && if_a.pat_o != target; i++) @(negedge clk);
    if (if_a.pat_o != target) begin
      n_chk++;
      $display("FAIL wait_pat: got pat 0x%0h, want 0x%0h", if_a.pat_o, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.start_i = 1'b0;
    if_a.abort_i = 1'b0;
    if_b.start_i = 1'b0;
    if_b.abort_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(if_a.busy_o), 0);
      check("idle_done", 32'(if_a.done_o), 0);
      check("idle_pass", 32'(if_a.pass_o), 0);
      check("idle_pat", 32'(if_a.pat_o), 0);
      check("idle_sig", 32'(if_a.sig_o), 0);
    end
    check("idle_b_busy", 32'(if_b.busy_o), 0);
    check("idle_b_sig", 32'(if_b.sig_o), 0);

    run(1'b0, 0, 8'h00, 1'b1, 1'b0);
    run(1'b0, 1, 8'h01, 1'b0, 1'b0);
    run(1'b0, 2, 8'h1D, 1'b0, 1'b0);
    run(1'b0, 3, 8'h03, 1'b0, 1'b0);
    run(1'b1, 0, 8'h00, 1'b0, 1'b0);
    run(1'b1, 2, 8'h1D, 1'b1, 1'b0);
    run(1'b0, 0, 8'h00, 1'b1, 1'b1);

    // Abort mid-run; any done pulse afterwards is flagged by the monitor.
    mode_a = 0;
    start_pulse(1'b0);
    wait_pat_a(5'd10);
    if_a.abort_i = 1'b1;
    @(negedge clk);
    if_a.abort_i = 1'b0;
    check("abort_busy", 32'(if_a.busy_o), 0);
    check("abort_done", 32'(if_a.done_o), 0);
    check("abort_pass", 32'(if_a.pass_o), 0);
    check("abort_sig", 32'(if_a.sig_o), 0);
    repeat (40) @(negedge clk);
    check("abort_stays_idle", 32'(if_a.busy_o), 0);
    run(1'b0, 0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-run with a non-trivial partial signature.
    mode_a = 4;
    start_pulse(1'b0);
    wait_pat_a(5'd5);
    check("pre_reset_sig", 32'(if_a.sig_o != 8'h00), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pat", 32'(if_a.pat_o), 0);
    check("rst_busy", 32'(if_a.busy_o), 0);
    check("rst_done", 32'(if_a.done_o), 0);
    check("rst_pass", 32'(if_a.pass_o), 0);
    check("rst_sig", 32'(if_a.sig_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_stays_idle", 32'(if_a.busy_o), 0);

    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
